// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared states and constants for the DSP job sequencer
package dsp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        STREAM,
        FLUSH,
        WAIT,
        DONE
    } state_t;

    localparam logic [1:0] MODE_DIRECT = 2'd0;
    localparam logic [1:0] MODE_PAIRS  = 2'd1;
    localparam logic [1:0] MODE_CROSS  = 2'd2;
    localparam logic [1:0] MODE_BFLY   = 2'd3;

    localparam int SAMPLE_W = 16;
    localparam int RESULT_W = 32;

endpackage

// File: rtl/dsp_job_sequencer.sv
// rtl/dsp_job_sequencer.sv - drives one DSP engine through load/clear/stream/flush/collect jobs
module dsp_job_sequencer
    import dsp_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [1:0]            job_mode,
    input  logic                  job_accum,
    input  logic [LEN_W-1:0]      job_len,
    input  logic [4*SAMPLE_W-1:0] job_coef,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*SAMPLE_W-1:0] in_samples,
    output logic [4*SAMPLE_W-1:0] eng_coef,
    output logic                  eng_coef_load,
    output logic                  eng_clear,
    output logic [1:0]            eng_mode,
    output logic                  eng_accumulate,
    output logic [4*SAMPLE_W-1:0] eng_samples,
    output logic                  eng_sample_valid,
    input  logic                  eng_result_valid,
    input  logic [4*RESULT_W-1:0] eng_result,
    input  logic                  eng_overflow,
    output logic                  busy,
    output logic                  done,
    output logic                  done_err,
    output logic [4*RESULT_W-1:0] res,
    output logic                  res_overflow
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;

    state_t                  state_q, state_d;
    logic [1:0]              mode_q;
    logic                    accum_q;
    logic [LEN_W-1:0]        len_q;
    logic [4*SAMPLE_W-1:0]   coef_q;
    logic [LEN_W-1:0]        beat_q, beat_d;
    logic [LEN_W:0]          rcnt_q, rcnt_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic                    err_q, err_d;
    logic [4*RESULT_W-1:0]   shadow_q, shadow_d;
    logic [4*RESULT_W-1:0]   res_q;
    logic                    ovf_q;
    logic                    collecting;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            accum_q  <= 1'b0;
            len_q    <= '0;
            coef_q   <= '0;
            beat_q   <= '0;
            rcnt_q   <= '0;
            wd_q     <= '0;
            err_q    <= 1'b0;
            shadow_q <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            rcnt_q   <= rcnt_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
            if (state_q == IDLE && job_valid) begin
                mode_q  <= job_mode;
                accum_q <= job_accum;
                len_q   <= job_len;
                coef_q  <= job_coef;
            end
            if (state_q == DONE) begin
                res_q <= shadow_q;
                ovf_q <= eng_overflow;
            end
        end
    end

    // Results can land from the first real beat onward, including the cycle that enters WAIT.
    assign collecting = (state_q == STREAM) || (state_q == FLUSH) || (state_q == WAIT);

    always_comb begin
        state_d          = state_q;
        beat_d           = beat_q;
        rcnt_d           = rcnt_q;
        wd_d             = wd_q;
        err_d            = err_q;
        shadow_d         = shadow_q;
        job_ready        = 1'b0;
        in_ready         = 1'b0;
        eng_coef         = '0;
        eng_coef_load    = 1'b0;
        eng_clear        = 1'b0;
        eng_samples      = '0;
        eng_sample_valid = 1'b0;
        done             = 1'b0;
        done_err         = 1'b0;

        if (collecting && eng_result_valid) begin
            rcnt_d   = rcnt_q + 1'b1;
            shadow_d = eng_result;
        end

        case (state_q)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) state_d = LOAD;
            end
            LOAD: begin
                eng_coef_load = 1'b1;
                eng_coef      = coef_q;
                state_d       = CLEAR;
            end
            CLEAR: begin
                eng_clear = 1'b1;
                beat_d    = '0;
                rcnt_d    = '0;
                err_d     = 1'b0;
                state_d   = (len_q != '0) ? STREAM : FLUSH;
            end
            STREAM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    eng_sample_valid = 1'b1;
                    eng_samples      = in_samples;
                    beat_d           = beat_q + 1'b1;
                    if (beat_d == len_q) state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Zero beat pushes the last real update out of the engine's one-deep report.
                eng_sample_valid = 1'b1;
                wd_d             = '0;
                state_d          = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                if (rcnt_d >= ({1'b0, len_q} + 1'b1)) begin
                    state_d = DONE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                done_err = err_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy           = (state_q != IDLE);
    assign eng_mode       = busy ? mode_q : 2'b00;
    assign eng_accumulate = busy ? accum_q : 1'b0;
    assign res            = (state_q == DONE) ? shadow_q : res_q;
    assign res_overflow   = (state_q == DONE) ? eng_overflow : ovf_q;

endmodule

// File: tb/tb_dsp_job_sequencer.sv
// tb/tb_dsp_job_sequencer.sv - directed self-checking bench with a behavioural engine model
module tb_dsp_job_sequencer;

    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             job_valid;
    logic             job_ready;
    logic [1:0]       job_mode;
    logic             job_accum;
    logic [LEN_W-1:0] job_len;
    logic [63:0]      job_coef;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_samples;
    logic [63:0]      eng_coef;
    logic             eng_coef_load;
    logic             eng_clear;
    logic [1:0]       eng_mode;
    logic             eng_accumulate;
    logic [63:0]      eng_samples;
    logic             eng_sample_valid;
    logic             eng_result_valid;
    logic [127:0]     eng_result;
    logic             eng_overflow;
    logic             busy;
    logic             done;
    logic             done_err;
    logic [127:0]     res;
    logic             res_overflow;

    dsp_job_sequencer #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_mode(job_mode),
        .job_accum(job_accum), .job_len(job_len), .job_coef(job_coef),
        .in_valid(in_valid), .in_ready(in_ready), .in_samples(in_samples),
        .eng_coef(eng_coef), .eng_coef_load(eng_coef_load), .eng_clear(eng_clear),
        .eng_mode(eng_mode), .eng_accumulate(eng_accumulate),
        .eng_samples(eng_samples), .eng_sample_valid(eng_sample_valid),
        .eng_result_valid(eng_result_valid), .eng_result(eng_result),
        .eng_overflow(eng_overflow), .busy(busy), .done(done), .done_err(done_err),
        .res(res), .res_overflow(res_overflow)
    );

    always #5 clk = ~clk;

    // Engine: reports the accumulator as it was before the beat being applied.
    logic        suppress = 1'b0;
    logic        ovf_force = 1'b0;
    logic [63:0] coef_m;
    logic signed [31:0] acc [4];

    function automatic logic signed [31:0] mul(input logic signed [15:0] a, input logic signed [15:0] b);
        logic signed [31:0] a32, b32;
        a32 = a;
        b32 = b;
        return a32 * b32;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_result_valid <= 1'b0;
            eng_result       <= '0;
            coef_m           <= '0;
            for (int k = 0; k < 4; k++) acc[k] <= '0;
        end else begin
            eng_result_valid <= 1'b0;
            if (eng_coef_load) coef_m <= eng_coef;
            if (eng_clear) begin
                for (int k = 0; k < 4; k++) acc[k] <= '0;
            end else if (eng_sample_valid) begin
                if (!(suppress && eng_samples == 64'd0)) begin
                    eng_result_valid <= 1'b1;
                    eng_result       <= {acc[3], acc[2], acc[1], acc[0]};
                end
                for (int k = 0; k < 4; k++)
                    acc[k] <= (eng_accumulate ? acc[k] : 32'sd0)
                              + mul(coef_m[16*k +: 16], eng_samples[16*k +: 16]);
            end
        end
    end
    assign eng_overflow = ovf_force;

    int mon_cyc = 0, mon_beats = 0, mon_flush = 0, mon_ready = 0, mon_done = 0;
    int mon_flush_cyc = 0, mon_done_cyc = 0;
    always @(negedge clk) begin
        mon_cyc <= mon_cyc + 1;
        if (eng_sample_valid && eng_samples == 64'd0) begin
            mon_flush     <= mon_flush + 1;
            mon_flush_cyc <= mon_cyc;
        end else if (eng_sample_valid) begin
            mon_beats <= mon_beats + 1;
        end
        if (in_ready) mon_ready <= mon_ready + 1;
        if (done) begin
            mon_done     <= mon_done + 1;
            mon_done_cyc <= mon_cyc;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    bit          vpat[$];
    logic [63:0] spat[$];

    logic [127:0] r_res;
    logic         r_ovf, r_err;
    int           r_gap, r_beats, r_flush, r_ready;

    task automatic run_job(input logic [1:0] mode, input logic accum, input logic [7:0] len,
                           input logic [63:0] coef, input bit wait_done);
        int b0, f0, rd0, k;
        bit got;
        b0 = mon_beats; f0 = mon_flush; rd0 = mon_ready;
        @(posedge clk); #1;
        job_valid = 1'b1; job_mode = mode; job_accum = accum; job_len = len; job_coef = coef;
        @(negedge clk); #1;
        check("job_ready_idle", job_ready, 1'b1);
        @(posedge clk); #1;
        job_valid = 1'b0; job_coef = '0; job_mode = '0; job_accum = 1'b0; job_len = '0;
        @(negedge clk); #1;
        check("coef_load", {eng_coef_load, eng_clear}, 2'b10);
        check("coef_value", eng_coef, coef);
        check("mode_held", {eng_mode, eng_accumulate, busy, job_ready}, {mode, accum, 2'b10});
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("clear", {eng_coef_load, eng_clear}, 2'b01);
        @(posedge clk); #1;
        k = 0;
        foreach (vpat[i]) begin
            in_valid   = vpat[i];
            in_samples = vpat[i] ? spat[k] : 64'hDEAD_BEEF_0BAD_F00D;
            @(posedge clk); #1;
            if (vpat[i]) k++;
        end
        in_valid = 1'b0; in_samples = '0;
        if (wait_done) begin
            got = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk); #1;
                if (done) begin got = 1'b1; break; end
            end
            check("done_seen", got, 1'b1);
            r_res = res; r_ovf = res_overflow; r_err = done_err;
            check("mode_at_done", {eng_mode, eng_accumulate}, {mode, accum});
            r_gap   = mon_done_cyc - mon_flush_cyc;
            r_beats = mon_beats - b0;
            r_flush = mon_flush - f0;
            r_ready = mon_ready - rd0;
            @(negedge clk); #1;
            check("idle_after_done", {job_ready, done, busy, eng_mode, eng_accumulate}, 6'b100000);
            check("res_held", res, r_res);
        end
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; job_valid = 1'b0; job_mode = '0; job_accum = 1'b0; job_len = '0;
        job_coef = '0; in_valid = 1'b0; in_samples = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset_ctrl", {job_ready, busy, done, done_err, in_ready, eng_sample_valid,
                             eng_coef_load, eng_clear, eng_mode, eng_accumulate}, 11'b10000000000);
        check("reset_res", {res, res_overflow}, 129'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Accumulate, lane0 1+2+3, lane1 -1 x3
        vpat = '{1, 1, 1};
        spat = '{64'h0000_0000_FFFF_0001, 64'h0000_0000_FFFF_0002, 64'h0000_0000_FFFF_0003};
        run_job(2'd0, 1'b1, 8'd3, 64'h0001_0001_0001_0001, 1'b1);
        check("acc_res", r_res, {32'd0, 32'd0, 32'hFFFF_FFFD, 32'd6});
        check("acc_flags", {r_ovf, r_err}, 2'b00);
        check("acc_gap", r_gap, 2);
        check("acc_beats", {r_beats[7:0], r_flush[7:0]}, {8'd3, 8'd1});

        // Non-accumulate: only the last beat survives
        vpat = '{1, 1};
        spat = '{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007};
        run_job(2'd0, 1'b0, 8'd2, 64'h0000_0000_0000_0002, 1'b1);
        check("noacc_res", r_res, {96'd0, 32'd14});
        check("noacc_err", r_err, 1'b0);

        // Zero-length job
        vpat = '{};
        spat = '{};
        run_job(2'd3, 1'b1, 8'd0, 64'h0005_0004_0003_0002, 1'b1);
        check("len0_res", r_res, 128'd0);
        check("len0_flush", {r_flush[7:0], r_beats[7:0], r_ready[7:0]}, {8'd1, 8'd0, 8'd0});
        check("len0_err", r_err, 1'b0);

        // Stalled stream with engine overflow raised
        ovf_force = 1'b1;
        vpat = '{1, 0, 0, 1, 1, 0, 1};
        spat = '{64'h0000_0000_0001_0001, 64'h0000_0000_0001_0002,
                 64'h0000_0000_0001_0003, 64'h0000_0000_0001_0004};
        run_job(2'd0, 1'b1, 8'd4, 64'h0000_0000_0003_0001, 1'b1);
        ovf_force = 1'b0;
        check("stall_res", r_res, {32'd0, 32'd0, 32'd12, 32'd10});
        check("stall_beats", {r_beats[7:0], r_flush[7:0]}, {8'd4, 8'd1});
        check("stall_flags", {r_ovf, r_err}, 2'b10);

        // Watchdog: flush result never arrives
        suppress = 1'b1;
        vpat = '{1, 1};
        spat = '{64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004};
        run_job(2'd0, 1'b1, 8'd2, 64'h0000_0000_0000_0001, 1'b1);
        suppress = 1'b0;
        check("wd_err", r_err, 1'b1);
        check("wd_gap", r_gap, TIMEOUT + 1);
        check("wd_res", r_res, {96'd0, 32'd3});

        // Reset in the middle of streaming
        d0 = mon_done;
        vpat = '{1, 1};
        spat = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002};
        run_job(2'd1, 1'b1, 8'd5, 64'h0000_0000_0000_0001, 1'b0);
        check("mid_busy", {busy, in_ready}, 2'b11);
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_samples = 64'h1111_2222_3333_4444;
        @(negedge clk); #1;
        check("rst_ctrl", {job_ready, busy, done, in_ready, eng_sample_valid, eng_coef_load,
                           eng_clear, eng_mode, eng_accumulate}, 10'b1000000000);
        check("rst_data", {eng_samples, eng_coef}, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0; in_samples = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_done", mon_done - d0, 0);

        vpat = '{1, 1};
        spat = '{64'h0000_0000_0000_0009, 64'h0000_0000_0000_0001};
        run_job(2'd0, 1'b1, 8'd2, 64'h0000_0000_0000_0001, 1'b1);
        check("post_rst_res", r_res, {96'd0, 32'd10});
        check("post_rst_flags", {r_ovf, r_err}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
